// File: rtl/cordic_atan_scheduler.sv
// ============================================================================
// Module   : cordic_atan_scheduler
// Purpose  : Round-robin front end for a shared atan engine, with in-order
//            tag tracking and a credit-gated show-ahead result FIFO.
//            Optional macro CORDIC_SCHED_ERRCHK_EN adds a sticky err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_atan_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_y,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            eng_in_valid,
    output logic [DATA_WIDTH-1:0]           eng_x,
    output logic [DATA_WIDTH-1:0]           eng_y,
    input  logic                            eng_out_valid,
    input  logic [DATA_WIDTH-1:0]           eng_angle,
    output logic                            res_valid,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic [DATA_WIDTH-1:0]           res_angle,
    input  logic                            res_ready,
    output logic                            busy
`ifdef CORDIC_SCHED_ERRCHK_EN
    ,
    output logic                            err
`endif
);

    localparam int c_ID_W = $clog2(NUM_REQ);
    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_CW   = $clog2(FIFO_DEPTH + 1);

    logic [c_ID_W-1:0]     r_ptr;
    logic                  r_eng_v;
    logic [DATA_WIDTH-1:0] r_eng_x;
    logic [DATA_WIDTH-1:0] r_eng_y;
    logic [c_CW-1:0]       r_inflight;
    logic [c_CW-1:0]       r_rcount;
    logic [c_ID_W-1:0]     r_tag_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_tag_wr;
    logic [c_AW-1:0]       r_tag_rd;
    logic [c_ID_W-1:0]     r_rid_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rang_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_res_wr;
    logic [c_AW-1:0]       r_res_rd;

    logic                  w_found;
    logic [c_ID_W-1:0]     w_gid;
    logic [c_ID_W:0]       w_idx;
    logic [c_ID_W-1:0]     w_ptr_nxt;
    logic [c_CW:0]         w_used;
    logic                  w_credit;
    logic                  w_hs;
    logic                  w_ret;
    logic                  w_pop;

    // Rotating priority search starting at r_ptr; sum stays below 2*NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_ID_W+1)'(k);
            if (w_idx >= (c_ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (c_ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gid   = w_idx[c_ID_W-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_gid == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gid + c_ID_W'(1);
    assign w_used    = {1'b0, r_inflight} + {1'b0, r_rcount};
    assign w_credit  = w_used < (c_CW+1)'(FIFO_DEPTH);
    assign w_hs      = resetn & w_found & w_credit;
    assign w_ret     = eng_out_valid & (r_inflight != '0);
    assign w_pop     = res_valid & res_ready;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_gid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr      <= '0;
            r_eng_v    <= 1'b0;
            r_eng_x    <= '0;
            r_eng_y    <= '0;
            r_inflight <= '0;
            r_rcount   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_res_wr   <= '0;
            r_res_rd   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_tag_mem[i]  <= '0;
                r_rid_mem[i]  <= '0;
                r_rang_mem[i] <= '0;
            end
        end else begin
            r_eng_v <= w_hs;
            if (w_hs) begin
                r_eng_x             <= req_x[w_gid*DATA_WIDTH +: DATA_WIDTH];
                r_eng_y             <= req_y[w_gid*DATA_WIDTH +: DATA_WIDTH];
                r_ptr               <= w_ptr_nxt;
                r_tag_mem[r_tag_wr] <= w_gid;
                r_tag_wr            <= r_tag_wr + c_AW'(1);
            end
            if (w_ret) begin
                r_tag_rd             <= r_tag_rd + c_AW'(1);
                r_rid_mem[r_res_wr]  <= r_tag_mem[r_tag_rd];
                r_rang_mem[r_res_wr] <= eng_angle;
                r_res_wr             <= r_res_wr + c_AW'(1);
            end
            if (w_pop) begin
                r_res_rd <= r_res_rd + c_AW'(1);
            end
            // Net change lets issue, return and pop coexist in one cycle.
            r_inflight <= r_inflight + c_CW'(w_hs) - c_CW'(w_ret);
            r_rcount   <= r_rcount + c_CW'(w_ret) - c_CW'(w_pop);
        end
    end

`ifdef CORDIC_SCHED_ERRCHK_EN
    logic r_err;
    logic w_drop;

    assign w_drop = eng_out_valid & (r_inflight == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign eng_in_valid = r_eng_v;
    assign eng_x        = r_eng_x;
    assign eng_y        = r_eng_y;
    assign res_valid    = (r_rcount != '0);
    assign res_id       = r_rid_mem[r_res_rd];
    assign res_angle    = r_rang_mem[r_res_rd];
    assign busy         = r_eng_v | (r_inflight != '0) | res_valid;

endmodule

`default_nettype wire

// File: tb/tb_cordic_atan_scheduler.sv
// ============================================================================
// Module   : tb_cordic_atan_scheduler
// Purpose  : Directed bench with a queue-level reference model and an
//            engine stand-in of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_atan_scheduler;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_x;
    logic [NR*DW-1:0]  req_y;
    logic [NR-1:0]     req_ready;
    logic              eng_in_valid;
    logic [DW-1:0]     eng_x;
    logic [DW-1:0]     eng_y;
    logic              eng_out_valid = 1'b0;
    logic [DW-1:0]     eng_angle = '0;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [DW-1:0]     res_angle;
    logic              res_ready;
    logic              busy;
`ifdef CORDIC_SCHED_ERRCHK_EN
    logic              err;
`endif

    cordic_atan_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_ready     (req_ready),
        .eng_in_valid  (eng_in_valid),
        .eng_x         (eng_x),
        .eng_y         (eng_y),
        .eng_out_valid (eng_out_valid),
        .eng_angle     (eng_angle),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_angle     (res_angle),
        .res_ready     (res_ready),
        .busy          (busy)
`ifdef CORDIC_SCHED_ERRCHK_EN
        ,
        .err           (err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine stand-in: fixed latency in auto mode, stimulus-driven in manual mode.
    int            eng_lat  = 4;
    bit            eng_auto = 1'b1;
    logic          man_ov   = 1'b0;
    logic [DW-1:0] man_ang  = '0;
    int            cyc      = 0;
    int            due_q[$];
    logic [DW-1:0] ang_q[$];

    function automatic logic [DW-1:0] f_atan(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (x == y) return 32'h002D_0000;
        return x ^ {y[15:0], y[31:16]};
    endfunction

    always @(posedge clk) begin
        #2;
        cyc++;
        if (eng_auto && eng_in_valid) begin
            due_q.push_back(cyc + eng_lat);
            ang_q.push_back(f_atan(eng_x, eng_y));
        end
        if (!eng_auto) begin
            eng_out_valid = man_ov;
            eng_angle     = man_ang;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            eng_out_valid = 1'b1;
            eng_angle     = ang_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            eng_out_valid = 1'b0;
            eng_angle     = '0;
        end
    end

    // Reference model: job queues plus the round-robin pointer.
    int            m_ptr = 0;
    bit            m_ev  = 1'b0;
    logic [DW-1:0] m_ex  = '0;
    logic [DW-1:0] m_ey  = '0;
    bit            m_err = 1'b0;
    int            tagq[$];
    int            rq_id[$];
    logic [DW-1:0] rq_ang[$];
    int            g_log[$];
    int            r_log[$];

    always @(negedge clk) begin
        int            g;
        int            idx;
        bit            found;
        int            credits;
        logic [NR-1:0] exp_rdy;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        credits = FD - (tagq.size() + rq_id.size());
        exp_rdy = '0;
        if (resetn === 1'b1 && found && credits > 0) exp_rdy[g] = 1'b1;

        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("eng_in_valid", 32'(eng_in_valid), 32'(m_ev));
        if (m_ev) begin
            chk("eng_x", eng_x, m_ex);
            chk("eng_y", eng_y, m_ey);
        end
        chk("res_valid", 32'(res_valid), 32'(rq_id.size() > 0));
        if (rq_id.size() > 0) begin
            chk("res_id", 32'(res_id), rq_id[0]);
            chk("res_angle", res_angle, rq_ang[0]);
        end
        chk("busy", 32'(busy), 32'(m_ev || tagq.size() > 0 || rq_id.size() > 0));
`ifdef CORDIC_SCHED_ERRCHK_EN
        chk("err", 32'(err), 32'(m_err));
`endif

        if (resetn === 1'b1 && (req_valid & req_ready) != '0) begin
            for (int k = 0; k < NR; k++) if (req_ready[k]) g_log.push_back(k);
        end
        if (resetn === 1'b1 && res_valid && res_ready) r_log.push_back(int'(res_id));

        if (resetn !== 1'b1) begin
            tagq.delete();
            rq_id.delete();
            rq_ang.delete();
            m_ptr = 0;
            m_ev  = 1'b0;
            m_ex  = '0;
            m_ey  = '0;
            m_err = 1'b0;
        end else begin
            if (eng_out_valid && tagq.size() == 0) m_err = 1'b1;
            if (rq_id.size() > 0 && res_ready) begin
                void'(rq_id.pop_front());
                void'(rq_ang.pop_front());
            end
            if (eng_out_valid && tagq.size() > 0) begin
                rq_id.push_back(tagq.pop_front());
                rq_ang.push_back(eng_angle);
            end
            m_ev = (exp_rdy != '0);
            if (m_ev) begin
                m_ex  = req_x[g*DW +: DW];
                m_ey  = req_y[g*DW +: DW];
                tagq.push_back(g);
                m_ptr = (g + 1) % NR;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || due_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n;
        resetn    = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_x[i*DW +: DW] = 32'h0001_0000 * (i + 1) + 32'h0000_0123;
            req_y[i*DW +: DW] = 32'h0000_0100 * (i + 3) + 32'h0050_0000;
        end
        repeat (2) tick();
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst res_valid", 32'(res_valid), 32'h0);
        chk("rst eng_in_valid", 32'(eng_in_valid), 32'h0);
        chk("rst eng_x", eng_x, 32'h0);
        chk("rst res_id", 32'(res_id), 32'h0);
        chk("rst res_angle", res_angle, 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // Round-robin order with all requesters held and slow engine
        eng_lat   = 16;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        n = 0;
        while (g_log.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        wait_idle(100);
        chk("rr grant count", 32'(g_log.size()), 32'd5);
        chk("rr result count", 32'(r_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr grant[%0d]", i), 32'(i < g_log.size() ? g_log[i] : -1), 32'(exp_order[i]));
            chk($sformatf("rr res_id[%0d]", i), 32'(i < r_log.size() ? r_log[i] : -1), 32'(exp_order[i]));
        end

        // Credit exhaustion with a stalled consumer
        g_log.delete();
        eng_lat   = 3;
        res_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (12) tick();
        chk("credit issues", 32'(g_log.size()), 32'd4);
        chk("credit first grant", 32'(g_log.size() > 0 ? g_log[0] : -1), 32'd1);
        chk("credit ready low", 32'(req_ready), 32'h0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        repeat (10) tick();
        chk("credit issues after pop", 32'(g_log.size()), 32'd5);
        chk("credit fifth grant", 32'(g_log.size() > 4 ? g_log[4] : -1), 32'd1);
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle(100);

        // Single job from requester 2 with known engine answer
        res_ready         = 1'b0;
        eng_lat           = 5;
        req_x[2*DW +: DW] = 32'h0001_0000;
        req_y[2*DW +: DW] = 32'h0001_0000;
        req_valid         = 4'b0100;
        tick();
        req_valid = '0;
        n = 0;
        while (res_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("single res_valid", 32'(res_valid), 32'h1);
        chk("single res_id", 32'(res_id), 32'd2);
        chk("single res_angle", res_angle, 32'h002D_0000);
        res_ready = 1'b1;
        wait_idle(50);

        // Issue, return and pop in one cycle at one remaining credit
        eng_auto  = 1'b0;
        res_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (3) tick();
        req_valid = '0;
        tick();
        man_ov  = 1'b1;
        man_ang = 32'hA5A5_0001;
        tick();
        man_ang = 32'hA5A5_0002;
        tick();
        req_valid = 4'b0001;
        man_ang   = 32'hA5A5_0003;
        res_ready = 1'b1;
        @(negedge clk);
        chk("credit1 ready", 32'(req_ready), 32'h1);
        chk("credit1 res_valid", 32'(res_valid), 32'h1);
        @(posedge clk);
        #1;
        man_ov    = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        chk("credit1 ready held", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        man_ov    = 1'b1;
        man_ang   = 32'hA5A5_0004;
        res_ready = 1'b1;
        tick();
        man_ang = 32'hA5A5_0005;
        tick();
        man_ov = 1'b0;
        wait_idle(50);
        eng_auto = 1'b1;

        // Reset with three jobs in flight; late returns must be dropped
        res_ready = 1'b1;
        eng_lat   = 10;
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        resetn    = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'h0);
        chk("post-reset res_valid", 32'(res_valid), 32'h0);
        repeat (15) tick();
        chk("late res_valid", 32'(res_valid), 32'h0);
        chk("late busy", 32'(busy), 32'h0);
`ifdef CORDIC_SCHED_ERRCHK_EN
        chk("late err", 32'(err), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cordic_atan_scheduler.md
CORDIC_ATAN_SCHEDULER -- requirements
Module: cordic_atan_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and angle width.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result FIFO depth and maximum outstanding jobs; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester job valid.
REQ-007 SHALL have port req_x, input, NUM_REQ*DATA_WIDTH bits: packed x operands; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_y, input, NUM_REQ*DATA_WIDTH bits: packed y operands, packed as req_x.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; one-hot or zero.
REQ-010 SHALL have port eng_in_valid, output, 1 bit: issue strobe to the atan engine.
REQ-011 SHALL have ports eng_x and eng_y, output, DATA_WIDTH bits each: engine operands.
REQ-012 SHALL have port eng_out_valid, input, 1 bit: engine result strobe.
REQ-013 SHALL have port eng_angle, input, DATA_WIDTH bits: engine result.
REQ-014 SHALL have port res_valid, output, 1 bit: result available.
REQ-015 SHALL have port res_id, output, $clog2(NUM_REQ) bits: originating requester index.
REQ-016 SHALL have port res_angle, output, DATA_WIDTH bits: result angle.
REQ-017 SHALL have port res_ready, input, 1 bit: consumer accept.
REQ-018 SHALL have port busy, output, 1 bit: any job issued, in flight or buffered.

Function
REQ-019 SHALL arbitrate round-robin: search starts at pointer ptr and the first asserted req_valid wins.
REQ-020 SHALL assert req_ready[g] combinationally for the winner g only when credits > 0; credits = FIFO_DEPTH - (inflight + fifo_count).
REQ-021 SHALL treat a handshake as req_valid[g] & req_ready[g], and on that edge set ptr to (g+1) mod NUM_REQ; ptr SHALL hold when no handshake occurs.
REQ-022 SHALL register the accepted req_x/req_y onto eng_x/eng_y and pulse eng_in_valid high for exactly one cycle after each handshake; at most one issue per cycle.
REQ-023 SHALL push g into an in-order tag FIFO of depth FIFO_DEPTH on each issue, and increment inflight.
REQ-024 SHALL, on eng_out_valid with tag FIFO non-empty: pop the tag, push {tag, eng_angle} into the result FIFO, and decrement inflight.
REQ-025 SHALL drop eng_out_valid arriving while the tag FIFO is empty, with no state change.
REQ-026 SHALL present the result FIFO head as show-ahead: res_valid = non-empty, res_id/res_angle = head entry, stable while res_valid & !res_ready.
REQ-027 SHALL pop the result FIFO on res_valid & res_ready.
REQ-028 SHALL support simultaneous issue, engine return and result pop in one cycle, updating inflight and fifo_count by net change.
REQ-029 SHALL never overflow either FIFO, since credit gating bounds inflight + fifo_count at FIFO_DEPTH.
REQ-030 SHALL keep credits unchanged when a credit is consumed and released in the same cycle; ready then stays asserted.
REQ-031 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-032 SHALL drive busy = eng_in_valid | (inflight != 0) | res_valid.

Reset
REQ-033 SHALL, while resetn = 0 at a clock edge, clear ptr, inflight, both FIFOs, eng_in_valid, eng_x, eng_y, res_id and res_angle to 0, with res_valid = 0 and busy = 0.
REQ-034 SHALL force req_ready to 0 while resetn = 0.
REQ-035 SHALL, on reset mid-operation, discard all in-flight and buffered jobs; later engine returns are dropped per REQ-025.

Configuration
REQ-036 SHALL, with macro CORDIC_SCHED_ERRCHK_EN defined, add output err (1 bit, reset 0), set sticky on an eng_out_valid dropped per REQ-025 and cleared only by reset.
REQ-037 SHALL, without CORDIC_SCHED_ERRCHK_EN, have no err port; behaviour SHALL otherwise be identical.

Verification
REQ-038 SHALL cover: req_valid=4'b1111 held, engine latency 16, res_ready=1 -> grants in order 0,1,2,3,0; res_id follows the same order.
REQ-039 SHALL cover: res_ready=0, FIFO_DEPTH=4, all requesters valid -> exactly 4 issues; req_ready=0 thereafter until one pop, then exactly 1 more issue.
REQ-040 SHALL cover: requester 2 only, x=0x00010000, y=0x00010000, engine returning 0x002D0000 -> res_id=2, res_angle=0x002D0000.
REQ-041 SHALL cover: issue, engine return and res pop in the same cycle at credits=1 -> req_ready stays 1 and no FIFO overflow.
REQ-042 SHALL cover: resetn low for 1 cycle with 3 jobs in flight -> busy=0 and res_valid=0; the 3 late eng_out_valid pulses are dropped, and err=1 when CORDIC_SCHED_ERRCHK_EN is defined.
